// File: rtl/cpu_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mmio_pkg
// Purpose : Shared IO map, status bit positions and UART FSM states.
// Revision: 1.0
// ============================================================================
package cpu_mmio_pkg;

    localparam logic [15:0] IO_BASE = 16'hF000;

    localparam logic [2:0] OFF_LED         = 3'd0;
    localparam logic [2:0] OFF_CYCLES      = 3'd1;
    localparam logic [2:0] OFF_UART_DATA   = 3'd2;
    localparam logic [2:0] OFF_UART_STATUS = 3'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic is_io(input logic [15:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : Transmit FIFO feeding an 8N1 serializer; LSB first, idle high.
// Revision: 1.0
// ============================================================================
module uart_tx
    import cpu_mmio_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    tx_state_e        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic push_ok;
    logic pop;
    logic baud_end;

    // Full/empty come from the registered count, so a same-cycle pop never
    // makes room for a push, and a fresh push is only visible next cycle.
    assign full_o   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o  = (count_q == '0);
    assign push_ok  = push_i && !full_o;
    assign baud_end = (baud_cnt_q == BAUD_LAST);
    assign pop      = !empty_o &&
                      ((state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_end));
    assign busy_o   = (state_q != TX_IDLE);
    assign tx_o     = tx_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        state_q    <= TX_START;
                        baud_cnt_q <= '0;
                        shift_q    <= mem_q[rd_ptr_q];
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (baud_end) begin
                        state_q    <= TX_DATA;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        if (pop) begin
                            state_q <= TX_START;
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mmio.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mmio
// Purpose : CPU bus splitter: RAM below 0xF000, LED/cycle counter/UART above.
// Revision: 1.0
// ============================================================================
module cpu_mmio
    import cpu_mmio_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_raddr_i,
    input  logic        cpu_rd_i,
    output logic [15:0] cpu_rdata_o,
    input  logic [15:0] cpu_waddr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic        cpu_wr_i,
    output logic [15:0] ram_raddr_o,
    input  logic [15:0] ram_rdata_i,
    output logic [15:0] ram_waddr_o,
    output logic [15:0] ram_wdata_o,
    output logic        ram_wr_o,
    output logic [15:0] led_o,
    output logic        uart_tx_o
);

    logic [15:0] led_q, led_d;
    logic [15:0] cycles_q, cycles_d;
    logic        ovf_q, ovf_d;
    logic        io_sel_q, io_sel_d;
    logic [15:0] io_rdata_q, io_rdata_d;

    logic        wr_en;
    logic        wr_io;
    logic [2:0]  woff;
    logic [2:0]  roff;
    logic        uart_push;
    logic        uart_full;
    logic        uart_empty;
    logic        uart_busy;
    logic [15:0] status;
    logic [15:0] io_mux;

    assign wr_en = cpu_wr_i && !reset;
    assign wr_io = wr_en && is_io(cpu_waddr_i);
    assign woff  = cpu_waddr_i[2:0];
    assign roff  = cpu_raddr_i[2:0];

    assign ram_raddr_o = cpu_raddr_i;
    assign ram_waddr_o = cpu_waddr_i;
    assign ram_wdata_o = cpu_wdata_i;
    assign ram_wr_o    = wr_en && !is_io(cpu_waddr_i);

    assign uart_push = wr_io && (woff == OFF_UART_DATA);

    uart_tx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx (
        .clk     (clk),
        .reset   (reset),
        .push_i  (uart_push),
        .data_i  (cpu_wdata_i[7:0]),
        .full_o  (uart_full),
        .empty_o (uart_empty),
        .busy_o  (uart_busy),
        .tx_o    (uart_tx_o)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = uart_full;
        status[ST_EMPTY] = uart_empty;
        status[ST_BUSY]  = uart_busy;
        status[ST_OVF]   = ovf_q;
    end

    // Sampled from current register values, so a same-cycle write is not seen.
    always_comb begin
        io_mux = '0;
        case (roff)
            OFF_LED:         io_mux = led_q;
            OFF_CYCLES:      io_mux = cycles_q;
            OFF_UART_STATUS: io_mux = status;
            default:         io_mux = '0;
        endcase
    end

    always_comb begin
        led_d      = led_q;
        cycles_d   = cycles_q + 16'd1;
        ovf_d      = ovf_q;
        io_sel_d   = io_sel_q;
        io_rdata_d = io_rdata_q;

        if (wr_io && (woff == OFF_LED)) led_d = cpu_wdata_i;

        if (wr_io && (woff == OFF_UART_STATUS)) ovf_d = 1'b0;
        else if (uart_push && uart_full)        ovf_d = 1'b1;

        if (cpu_rd_i) begin
            io_sel_d   = is_io(cpu_raddr_i);
            io_rdata_d = io_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= '0;
            cycles_q   <= '0;
            ovf_q      <= 1'b0;
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            led_q      <= led_d;
            cycles_q   <= cycles_d;
            ovf_q      <= ovf_d;
            io_sel_q   <= io_sel_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign led_o       = led_q;
    assign cpu_rdata_o = io_sel_q ? io_rdata_q : ram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mmio
// Purpose : Self-checking bench for cpu_mmio against a behavioural model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_mmio;

    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_raddr_i;
    logic        cpu_rd_i;
    logic [15:0] cpu_rdata_o;
    logic [15:0] cpu_waddr_i;
    logic [15:0] cpu_wdata_i;
    logic        cpu_wr_i;
    logic [15:0] ram_raddr_o;
    logic [15:0] ram_rdata_i;
    logic [15:0] ram_waddr_o;
    logic [15:0] ram_wdata_o;
    logic        ram_wr_o;
    logic [15:0] led_o;
    logic        uart_tx_o;

    int checks = 0;
    int errors = 0;
    int n_cyc  = 0;
    logic [15:0] model_led;

    always #5 clk = ~clk;

    // Clock edges seen since the last reset: the architectural cycle count.
    always @(posedge clk) begin
        if (reset) n_cyc <= 0;
        else       n_cyc <= n_cyc + 1;
    end

    cpu_mmio #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_raddr_i (cpu_raddr_i),
        .cpu_rd_i    (cpu_rd_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_waddr_i (cpu_waddr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_wr_i    (cpu_wr_i),
        .ram_raddr_o (ram_raddr_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_waddr_o (ram_waddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wr_o    (ram_wr_o),
        .led_o       (led_o),
        .uart_tx_o   (uart_tx_o)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Line level k cycles into an 8N1 frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < BD)     return 1'b0;
        if (k < 9 * BD) return b[(k - BD) / BD];
        return 1'b1;
    endfunction

    task automatic test_reset;
        reset = 1'b1; cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF000; cpu_wdata_i = 16'hFFFF;
        cpu_rd_i = 1'b1; cpu_raddr_i = 16'hF001; ram_rdata_i = 16'h1357;
        repeat (3) step();
        checks++; if (led_o !== 16'h0000) begin errors++; $display("FAIL reset_led got %h want 0000", led_o); end
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx_o); end
        checks++; if (cpu_rdata_o !== 16'h1357) begin errors++; $display("FAIL reset_iosel got %h want 1357", cpu_rdata_o); end
        reset = 1'b0; cpu_wr_i = 1'b0; cpu_raddr_i = 16'hF003;
        step();
        cpu_rd_i = 1'b0;
        checks++; if (cpu_rdata_o !== 16'h0002) begin errors++; $display("FAIL reset_status got %h want 0002", cpu_rdata_o); end
        checks++; if (led_o !== 16'h0000) begin errors++; $display("FAIL reset_wr_ignored got %h want 0000", led_o); end
        model_led = 16'h0000;
    endtask

    task automatic test_led;
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF000; cpu_wdata_i = 16'hA5A5;
        #1;
        checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL led_ram_wr got %b want 0", ram_wr_o); end
        step();
        cpu_wr_i = 1'b0; model_led = 16'hA5A5;
        checks++; if (led_o !== model_led) begin errors++; $display("FAIL led_write got %h want %h", led_o, model_led); end
        cpu_rd_i = 1'b1; cpu_raddr_i = 16'hF000;
        step();
        checks++; if (cpu_rdata_o !== 16'hA5A5) begin errors++; $display("FAIL led_read got %h want a5a5", cpu_rdata_o); end
        cpu_wr_i = 1'b1; cpu_wdata_i = 16'h5A5A;
        step();
        cpu_wr_i = 1'b0; cpu_rd_i = 1'b0; model_led = 16'h5A5A;
        checks++; if (cpu_rdata_o !== 16'hA5A5) begin errors++; $display("FAIL led_rw_same got %h want a5a5", cpu_rdata_o); end
        checks++; if (led_o !== model_led) begin errors++; $display("FAIL led_rw_new got %h want %h", led_o, model_led); end
        step();
        checks++; if (cpu_rdata_o !== 16'hA5A5) begin errors++; $display("FAIL led_hold got %h want a5a5", cpu_rdata_o); end
    endtask

    task automatic test_ram;
        cpu_rd_i = 1'b1; cpu_raddr_i = 16'h1234;
        #1;
        checks++; if (ram_raddr_o !== 16'h1234) begin errors++; $display("FAIL ram_raddr got %h want 1234", ram_raddr_o); end
        step();
        cpu_rd_i = 1'b0; ram_rdata_i = 16'hBEEF;
        #1;
        checks++; if (cpu_rdata_o !== 16'hBEEF) begin errors++; $display("FAIL ram_read got %h want beef", cpu_rdata_o); end
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'h1234; cpu_wdata_i = 16'h0042;
        #1;
        checks++; if ({ram_wr_o, ram_waddr_o, ram_wdata_o} !== {1'b1, 16'h1234, 16'h0042}) begin
            errors++; $display("FAIL ram_write got %b %h %h want 1 1234 0042", ram_wr_o, ram_waddr_o, ram_wdata_o);
        end
        step();
        cpu_wr_i = 1'b0;
        #1;
        checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL ram_wr_pulse got %b want 0", ram_wr_o); end
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'hEFFF;
        #1;
        checks++; if (ram_wr_o !== 1'b1) begin errors++; $display("FAIL ram_top got %b want 1", ram_wr_o); end
        cpu_waddr_i = 16'hF004;
        #1;
        checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL io_bottom got %b want 0", ram_wr_o); end
        step();
        cpu_wr_i = 1'b0;
        checks++; if (led_o !== model_led) begin errors++; $display("FAIL unmapped_wr got %h want %h", led_o, model_led); end
    endtask

    task automatic test_random;
        int kind;
        logic [15:0] exp;
        logic [2:0]  offs [5] = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            ram_rdata_i = 16'($urandom);
            cpu_rd_i = 1'b1;
            cpu_wr_i = 1'b0;
            if (kind == 0) begin
                cpu_raddr_i = 16'($urandom_range(0, 16'hEFFF));
                step();
                cpu_rd_i = 1'b0;
                ram_rdata_i = 16'($urandom);
                #1;
                exp = ram_rdata_i;
            end else if (kind == 1) begin
                cpu_raddr_i = 16'hF000 | (16'($urandom) & 16'h0FF8);
                cpu_wr_i    = 1'($urandom);
                cpu_waddr_i = 16'hF000 | (16'($urandom) & 16'h0FF8);
                cpu_wdata_i = 16'($urandom);
                exp = model_led;
                step();
                if (cpu_wr_i) model_led = cpu_wdata_i;
                cpu_wr_i = 1'b0;
            end else begin
                cpu_raddr_i = 16'hF000 | (16'($urandom) & 16'h0FF8) | 16'(offs[$urandom_range(0, 4)]);
                exp = 16'h0000;
                step();
            end
            checks++; if (cpu_rdata_o !== exp) begin errors++; $display("FAIL rand_read[%0d] addr %h got %h want %h", i, cpu_raddr_i, cpu_rdata_o, exp); end
            checks++; if (led_o !== model_led) begin errors++; $display("FAIL rand_led[%0d] got %h want %h", i, led_o, model_led); end
        end
        cpu_rd_i = 1'b0;
    endtask

    task automatic test_cycles;
        logic [15:0] exp, v1, v2;
        int n, guard;
        cpu_rd_i = 1'b1; cpu_raddr_i = 16'hF001;
        exp = 16'(n_cyc);
        step();
        cpu_rd_i = 1'b0; v1 = cpu_rdata_o;
        checks++; if (v1 !== exp) begin errors++; $display("FAIL cycles_abs got %h want %h", v1, exp); end
        n = int'($urandom_range(5, 300));
        repeat (n - 1) step();
        cpu_rd_i = 1'b1;
        step();
        cpu_rd_i = 1'b0; v2 = cpu_rdata_o;
        checks++; if (16'(v2 - v1) !== 16'(n)) begin errors++; $display("FAIL cycles_delta got %0d want %0d", 16'(v2 - v1), n); end
        guard = 0;
        while ((n_cyc != 65535) && (guard < 70000)) begin step(); guard++; end
        checks++; if (n_cyc != 65535) begin errors++; $display("FAIL cycles_preload got %0d want 65535", n_cyc); end
        cpu_rd_i = 1'b1;
        step();
        checks++; if (cpu_rdata_o !== 16'hFFFF) begin errors++; $display("FAIL cycles_max got %h want ffff", cpu_rdata_o); end
        step();
        cpu_rd_i = 1'b0;
        checks++; if (cpu_rdata_o !== 16'h0000) begin errors++; $display("FAIL cycles_wrap got %h want 0000", cpu_rdata_o); end
    endtask

    task automatic test_uart_frame;
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF002; cpu_wdata_i = 16'h0055;
        step();
        cpu_wr_i = 1'b0; cpu_rd_i = 1'b1; cpu_raddr_i = 16'hF003;
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL frame_pre got %b want 1", uart_tx_o); end
        for (int i = 0; i <= FRAME; i++) begin
            step();
            checks++; if (uart_tx_o !== frame_bit(8'h55, i)) begin errors++; $display("FAIL frame_bit[%0d] got %b want %b", i, uart_tx_o, frame_bit(8'h55, i)); end
            if (i >= 1) begin
                checks++; if (cpu_rdata_o[2] !== 1'b1) begin errors++; $display("FAIL frame_busy[%0d] got %b want 1", i, cpu_rdata_o[2]); end
            end
        end
        step();
        cpu_rd_i = 1'b0;
        checks++; if (cpu_rdata_o[3:0] !== 4'b0010) begin errors++; $display("FAIL frame_done got %b want 0010", cpu_rdata_o[3:0]); end
    endtask

    task automatic test_back_to_back;
        localparam int NS = 1 + (DEPTH + 1) * FRAME + 9;
        logic [7:0] bytes [DEPTH + 2];
        logic       txs   [NS];
        logic       exp;
        int         bad;
        for (int i = 0; i < DEPTH + 2; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < NS; i++) begin
            if (i < DEPTH + 2) begin
                cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF002; cpu_wdata_i = {8'($urandom), bytes[i]};
            end else begin
                cpu_wr_i = 1'b0;
            end
            cpu_rd_i = (i == DEPTH + 2); cpu_raddr_i = 16'hF003;
            step();
            txs[i] = uart_tx_o;
            if (i == DEPTH + 2) begin
                checks++; if ({cpu_rdata_o[3], cpu_rdata_o[0]} !== 2'b11) begin
                    errors++; $display("FAIL ovf_status got ovf=%b full=%b want 1 1", cpu_rdata_o[3], cpu_rdata_o[0]);
                end
            end
        end
        cpu_rd_i = 1'b0;
        // The first byte starts sending one cycle after its push, freeing a
        // slot, so exactly DEPTH+1 of the DEPTH+2 bytes survive.
        for (int f = 0; f < DEPTH + 1; f++) begin
            bad = -1;
            for (int k = 0; k < FRAME; k++) begin
                exp = frame_bit(bytes[f], k);
                if ((txs[1 + f * FRAME + k] !== exp) && (bad < 0)) bad = k;
            end
            checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_frame[%0d] first bad cycle %0d got %b want %b", f, bad, txs[1 + f * FRAME + bad], frame_bit(bytes[f], bad)); end
        end
        bad = 0;
        for (int i = 1 + (DEPTH + 1) * FRAME; i < NS; i++) if (txs[i] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_extra_frame got %0d low cycles want 0", bad); end
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF003;
        step();
        cpu_wr_i = 1'b0; cpu_rd_i = 1'b1;
        step();
        cpu_rd_i = 1'b0;
        checks++; if (cpu_rdata_o !== 16'h0002) begin errors++; $display("FAIL ovf_clear got %h want 0002", cpu_rdata_o); end
    endtask

    task automatic test_reset_mid_frame;
        int low;
        cpu_wr_i = 1'b1; cpu_waddr_i = 16'hF002; cpu_wdata_i = 16'h00C3;
        step();
        cpu_wr_i = 1'b0;
        repeat (3 * BD) step();
        reset = 1'b1;
        step();
        reset = 1'b0; model_led = 16'h0000;
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx got %b want 1", uart_tx_o); end
        cpu_rd_i = 1'b1; cpu_raddr_i = 16'hF003;
        step();
        cpu_rd_i = 1'b0;
        checks++; if ({cpu_rdata_o[2], cpu_rdata_o[1]} !== 2'b01) begin
            errors++; $display("FAIL abort_status got busy=%b empty=%b want 0 1", cpu_rdata_o[2], cpu_rdata_o[1]);
        end
        checks++; if (led_o !== model_led) begin errors++; $display("FAIL abort_led got %h want %h", led_o, model_led); end
        low = 0;
        for (int i = 0; i < FRAME + 4; i++) begin step(); if (uart_tx_o !== 1'b1) low++; end
        checks++; if (low != 0) begin errors++; $display("FAIL abort_idle got %0d low cycles want 0", low); end
    endtask

    initial begin
        reset = 1'b1; cpu_raddr_i = '0; cpu_rd_i = 1'b0; cpu_waddr_i = '0;
        cpu_wdata_i = '0; cpu_wr_i = 1'b0; ram_rdata_i = '0; model_led = '0;
        test_reset();
        test_led();
        test_ram();
        test_random();
        test_uart_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_cycles();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mmio.md
CPU_MMIO -- requirements
Module: cpu_mmio

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: depth of the UART transmit FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cpu_raddr_i, input, 16 bits: CPU read address, valid every cycle.
REQ-006 SHALL have port cpu_rd_i, input, 1 bit: CPU read enable.
REQ-007 SHALL have port cpu_rdata_o, output, 16 bits: read data for the address presented one cycle earlier.
REQ-008 SHALL have ports cpu_waddr_i (input, 16), cpu_wdata_i (input, 16) and cpu_wr_i (input, 1): CPU write port, single cycle.
REQ-009 SHALL have port ram_raddr_o, output, 16 bits: RAM read address, equal to cpu_raddr_i combinationally.
REQ-010 SHALL have port ram_rdata_i, input, 16 bits: RAM read data with a 1-cycle synchronous read.
REQ-011 SHALL have ports ram_waddr_o (output, 16), ram_wdata_o (output, 16) and ram_wr_o (output, 1): RAM write port.
REQ-012 SHALL have port led_o, output, 16 bits: LED register.
REQ-013 SHALL have port uart_tx_o, output, 1 bit: UART serial output, 8N1, idle high.

Function
REQ-014 SHALL decode addresses as: 0x0000-0xEFFF RAM; 0xF000-0xFFFF IO; only the low 3 address bits select within IO, so IO aliases.
REQ-015 SHALL map the IO registers as:
- 0xF000 LED: read/write.
- 0xF001 CYCLES: read-only.
- 0xF002 UART_DATA: write pushes wdata[7:0]; reads return 0.
- 0xF003 UART_STATUS: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky); a write clears overflow.
- Any other offset: reads 0, writes ignored.
REQ-016 SHALL drive ram_wr_o as cpu_wr_i AND the write address is in RAM, combinationally; ram_waddr_o and ram_wdata_o pass through unchanged.
REQ-017 SHALL register an io_sel flag and IO read data in the cycle the read address is presented; in the following cycle cpu_rdata_o is the registered IO value if io_sel, otherwise ram_rdata_i.
REQ-018 SHALL return the pre-write value when a read and a write hit the same IO register in the same cycle.
REQ-019 SHALL make reads free of side effects; cpu_rd_i only gates capture of io_sel and read data, and when it is low the previous capture is held.
REQ-020 SHALL increment CYCLES every cycle, wrapping from 0xFFFF to 0x0000.
REQ-021 SHALL treat a UART_DATA write while the FIFO is full as follows: data dropped, overflow set; a simultaneous pop frees no slot for that write.
REQ-022 SHALL allow a push into an empty FIFO to be popped no earlier than the next cycle.
REQ-023 SHALL run the serializer as an FSM IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE; each state lasts BAUD_DIV cycles.
REQ-024 SHALL pop the FIFO on the IDLE->START transition when the FIFO is not empty.
REQ-025 SHALL permit STOP to go directly to START when the FIFO is non-empty, with no idle gap.
REQ-026 SHALL assert tx_busy whenever the FSM is not IDLE.

Reset
REQ-027 SHALL reset as follows: led_o=0, CYCLES=0, FIFO empty, overflow=0, FSM IDLE, uart_tx_o=1, io_sel=0, registered IO data=0.
REQ-028 SHALL abort any in-flight UART frame on reset and drive the line high on the next cycle; no partial-frame recovery.
REQ-029 SHALL ignore cpu_wr_i while reset is asserted.

Structure
REQ-030 SHALL define the IO base, register offsets and status bit indices in shared package cpu_mmio_pkg.
REQ-031 SHALL implement the FIFO plus serializer as sub-module uart_tx (parameters BAUD_DIV, FIFO_DEPTH; push/data/full/empty/busy/tx ports).

Verification
REQ-032 SHALL cover: write 0xA5A5 to 0xF000, then read 0xF000 -> led_o=0xA5A5 after the write edge; cpu_rdata_o=0xA5A5 one cycle after the read address; ram_wr_o stays 0.
REQ-033 SHALL cover: read 0x1234 while ram_rdata_i=0xBEEF the next cycle -> cpu_rdata_o=0xBEEF; write 0x0042 to 0x1234 -> ram_wr_o=1 for that cycle only.
REQ-034 SHALL cover: read 0xF001 twice, N cycles apart -> difference equals N mod 65536; preload near 0xFFFF by counting from reset and verify the wrap.
REQ-035 SHALL cover, with BAUD_DIV=4: write 0x55 to 0xF002 -> uart_tx_o low 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; busy=1 throughout.
REQ-036 SHALL cover: FIFO_DEPTH+2 back-to-back writes while busy -> status full=1, overflow=1; exactly FIFO_DEPTH+1 frames emitted, back-to-back; writing 0xF003 clears overflow.
REQ-037 SHALL cover: reset asserted mid-DATA -> uart_tx_o=1, status empty=1, busy=0 on the cycle after reset.
